// File: rtl/riscv_lsu.sv
// Load/store unit: splits word-spanning accesses into two word accesses; merges and extends load data.
// Latency 1 (error) to 4 (spanning load) cycles; one access in flight, req_ready low until RESP, no response backpressure.
module riscv_lsu #(
  parameter int MISALIGNED_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, A0, A1, WAIT, RESP} state_t;

  state_t      state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_span;
  logic        r_err;
  logic [3:0]  r_be_hi;
  logic [31:0] r_wdata;
  logic [31:0] w0;
  logic [31:0] w1;

  logic [2:0]  in_size;
  logic [3:0]  in_mask;
  logic [7:0]  in_be;
  logic        in_span;
  logic        in_err;

  function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b101:  load_ext = {16'h0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  // Request decode; only ever registered, never routed straight to the memory port.
  always_comb begin
    in_size = 3'd4;
    in_mask = 4'b1111;
    case (funct3[1:0])
      2'b00: begin in_size = 3'd1; in_mask = 4'b0001; end
      2'b01: begin in_size = 3'd2; in_mask = 4'b0011; end
      default: ;
    endcase
    in_be   = {4'b0000, in_mask} << addr[1:0];
    in_span = ({1'b0, addr[1:0]} + in_size) > 3'd4;
    in_err  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (req_we && funct3[2]) || ((MISALIGNED_EN == 0) && in_span);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_wd     <= '0;
      r_we       <= 1'b0;
      r_f3       <= '0;
      r_off      <= '0;
      r_span     <= 1'b0;
      r_err      <= 1'b0;
      r_be_hi    <= '0;
      r_wdata    <= '0;
      w0         <= '0;
      w1         <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          r_we      <= req_we;
          r_f3      <= funct3;
          r_off     <= addr[1:0];
          r_span    <= in_span;
          r_err     <= in_err;
          r_be_hi   <= in_be[7:4];
          r_wdata   <= wdata;
          if (in_err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            // Strobes for A0 are loaded here so they appear registered in the A0 cycle.
            state    <= A0;
            mem_addr <= {addr[31:2], 2'b00};
            if (req_we) begin
              mem_we <= 1'b1;
              mem_be <= in_be[3:0];
              mem_wd <= wdata << {addr[1:0], 3'b000};
            end else begin
              mem_re <= 1'b1;
            end
          end
        end
        A0: begin
          if (r_span) begin
            state    <= A1;
            mem_addr <= mem_addr + 32'd4;
            if (r_we) begin
              mem_we <= 1'b1;
              mem_be <= r_be_hi;
              mem_wd <= r_wdata >> (6'd32 - {1'b0, r_off, 3'b000});
            end else begin
              mem_re <= 1'b1;
            end
          end else if (r_we) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        A1: begin
          if (r_we) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            w0    <= mem_rd;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (r_span) w1 <= mem_rd;
          else        w0 <= mem_rd;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    resp_rdata = '0;
    if (state == RESP && !r_we && !r_err) resp_rdata = load_ext({w1, w0}, r_off, r_f3);
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: word-addressed memory model, response scoreboard, strobe monitor.
module tb_riscv_lsu;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
  logic        mem_re, mem_we;
  logic [3:0]  mem_be;

  logic        req_valid_b, req_ready_b, resp_valid_b, resp_err_b, mem_re_b, mem_we_b;
  logic [31:0] resp_rdata_b, mem_addr_b, mem_wd_b, mem_rd_b;
  logic [3:0]  mem_be_b;

  riscv_lsu #(.MISALIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wd(mem_wd), .mem_rd(mem_rd));

  riscv_lsu #(.MISALIGNED_EN(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .resp_valid(resp_valid_b),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .mem_addr(mem_addr_b), .mem_re(mem_re_b),
    .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b));

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] act_q[$];
  int          lat_q[$];
  logic [31:0] re_addr_q[$], we_addr_q[$], we_wd_q[$];
  logic [3:0]  we_be_q[$];
  int          re_cnt, we_cnt;
  int          cyc = 0;
  int          last_acc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mem [0:1023];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read data memory: data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rd <= mem[mem_addr[11:2]];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wd[8*b +: 8];
  end

  always @(negedge clk) begin
    if (mem_re) begin re_cnt++; re_addr_q.push_back(mem_addr); end
    if (mem_we) begin
      we_cnt++;
      we_addr_q.push_back(mem_addr);
      we_be_q.push_back(mem_be);
      we_wd_q.push_back(mem_wd);
    end
    if (resp_valid) begin
      act_q.push_back({resp_err, resp_rdata});
      lat_q.push_back(cyc - last_acc + 1);
    end
  end

  task automatic clear_mon();
    re_cnt = 0; we_cnt = 0;
    re_addr_q.delete(); we_addr_q.delete(); we_be_q.delete(); we_wd_q.delete();
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                      input int e_lat, input bit push);
    int n;
    @(negedge clk);
    req_we = we; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    last_acc  = cyc;
    req_valid = 1'b0;
    if (push) exp_q.push_back('{e_err, e_rd, e_lat});
  endtask

  task automatic collect(output bit got, output logic [32:0] act, output int lat);
    got = 1'b0; act = '0; lat = 0;
    for (int i = 0; i < 40 && act_q.size() == 0; i++) begin @(negedge clk); #1; end
    if (act_q.size() != 0) begin
      got = 1'b1;
      act = act_q.pop_front();
      lat = lat_q.pop_front();
    end
  endtask

  task automatic b_req(input logic [2:0] f3, input logic [31:0] a, output int lat,
                       output logic err, output int strobes, output logic [31:0] first_addr);
    @(negedge clk);
    req_we = 1'b0; funct3 = f3; addr = a; req_valid_b = 1'b1;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    lat = 0; err = 1'b0; strobes = 0; first_addr = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_re_b || mem_we_b) begin
        if (strobes == 0) first_addr = mem_addr_b;
        strobes++;
      end
      if (resp_valid_b) begin lat = i; err = resp_err_b; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_be, req_ready_b} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b err=%b rd=%h re=%b we=%b be=%b rdy_b=%b exp 1 0 0 0 0 0 0 1",
               req_ready, resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_be, req_ready_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_aligned_loads();
    logic [2:0]  f3s [5] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010};
    logic [31:0] as  [5] = '{32'h108, 32'h10A, 32'h104, 32'h104, 32'h10C};
    logic [31:0] es  [5] = '{32'hffffbeef, 32'h0000dead, 32'hffffffde, 32'h000000de, 32'hc001c0de};
    bit got; logic [32:0] act; int lat; exp_t e;
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      send(1'b0, f3s[i], as[i], 32'h0, 1'b0, es[i], 3, 1'b1);
      collect(got, act, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (!got || act !== {e.err, e.rd} || lat != e.lat) begin
        n_fail++;
        $display("FAIL aligned_load[%0d] got=%0b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 i, got, act[32], act[31:0], lat, e.err, e.rd, e.lat);
      end
      n_tests++;
      if (re_cnt != 1 || we_cnt != 0) begin
        n_fail++;
        $display("FAIL aligned_load_strobes[%0d] re=%0d we=%0d exp re=1 we=0", i, re_cnt, we_cnt);
      end
    end
  endtask

  task automatic test_store_byte();
    bit got; logic [32:0] act; int lat; exp_t e;
    clear_mon();
    send(1'b1, 3'b000, 32'h105, 32'h123456ab, 1'b0, 32'h0, 2, 1'b1);
    collect(got, act, lat);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || act !== {e.err, e.rd} || lat != e.lat) begin
      n_fail++;
      $display("FAIL store_byte_resp got=%0b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
               got, act[32], act[31:0], lat, e.err, e.rd, e.lat);
    end
    n_tests++;
    if (we_cnt != 1 || we_be_q.size() != 1 || we_be_q[0] !== 4'b0010 || we_wd_q[0][15:8] !== 8'hab ||
        we_addr_q[0] !== 32'h104 || mem[32'h104 >> 2] !== 32'hdeadabde) begin
      n_fail++;
      $display("FAIL store_byte_write we=%0d mem104=%h exp we=1 be=0010 lane1=ab mem104=deadabde",
               we_cnt, mem[32'h104 >> 2]);
    end
  endtask

  task automatic test_span_load();
    bit got; logic [32:0] act; int lat; exp_t e;
    clear_mon();
    send(1'b0, 3'b010, 32'h109, 32'h0, 1'b0, 32'hdedeadbe, 4, 1'b1);
    collect(got, act, lat);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || act !== {e.err, e.rd} || lat != e.lat) begin
      n_fail++;
      $display("FAIL span_load_resp got=%0b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
               got, act[32], act[31:0], lat, e.err, e.rd, e.lat);
    end
    n_tests++;
    if (re_cnt != 2 || re_addr_q.size() != 2 || re_addr_q[0] !== 32'h108 || re_addr_q[1] !== 32'h10c) begin
      n_fail++;
      $display("FAIL span_load_reads re=%0d exp 2 reads at 108 then 10c", re_cnt);
    end
  endtask

  task automatic test_span_store();
    bit got; logic [32:0] act; int lat; exp_t e;
    clear_mon();
    send(1'b1, 3'b001, 32'h10B, 32'h00001234, 1'b0, 32'h0, 3, 1'b1);
    collect(got, act, lat);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || act !== {e.err, e.rd} || lat != e.lat) begin
      n_fail++;
      $display("FAIL span_store_resp got=%0b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
               got, act[32], act[31:0], lat, e.err, e.rd, e.lat);
    end
    n_tests++;
    if (we_cnt != 2 || we_be_q.size() != 2) begin
      n_fail++;
      $display("FAIL span_store_count we=%0d exp 2", we_cnt);
    end else if (we_be_q[0] !== 4'b1000 || we_wd_q[0][31:24] !== 8'h34 || we_addr_q[0] !== 32'h108 ||
                 we_be_q[1] !== 4'b0001 || we_wd_q[1][7:0] !== 8'h12 || we_addr_q[1] !== 32'h10c) begin
      n_fail++;
      $display("FAIL span_store_lanes be0=%b wd0=%h a0=%h be1=%b wd1=%h a1=%h exp 1000 34xxxxxx 108 0001 xxxxxx12 10c",
               we_be_q[0], we_wd_q[0], we_addr_q[0], we_be_q[1], we_wd_q[1], we_addr_q[1]);
    end
    n_tests++;
    if (mem[32'h108 >> 2] !== 32'h34adbeef || mem[32'h10C >> 2] !== 32'hc001c012) begin
      n_fail++;
      $display("FAIL span_store_mem got 108=%h 10c=%h exp 34adbeef c001c012",
               mem[32'h108 >> 2], mem[32'h10C >> 2]);
    end
    send(1'b0, 3'b010, 32'h108, 32'h0, 1'b0, 32'h34adbeef, 3, 1'b1);
    collect(got, act, lat);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || act !== {e.err, e.rd} || lat != e.lat) begin
      n_fail++;
      $display("FAIL span_store_readback got=%0b rdata=%h lat=%0d exp rdata=%h lat=%0d",
               got, act[31:0], lat, e.rd, e.lat);
    end
  endtask

  task automatic test_errors();
    logic        wes [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [3] = '{3'b011, 3'b100, 3'b110};
    bit got; logic [32:0] act; int lat; exp_t e;
    int b_lat, b_str; logic b_err; logic [31:0] b_addr;
    for (int i = 0; i < 3; i++) begin
      clear_mon();
      send(wes[i], f3s[i], 32'h100, 32'hffffffff, 1'b1, 32'h0, 1, 1'b1);
      collect(got, act, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (!got || act !== {e.err, e.rd} || lat != e.lat || re_cnt != 0 || we_cnt != 0) begin
        n_fail++;
        $display("FAIL illegal_op[%0d] got=%0b err=%b rdata=%h lat=%0d re=%0d we=%0d exp err=1 rdata=0 lat=1 no strobes",
                 i, got, act[32], act[31:0], lat, re_cnt, we_cnt);
      end
    end
    b_req(3'b010, 32'h109, b_lat, b_err, b_str, b_addr);
    n_tests++;
    if (b_lat != 1 || b_err !== 1'b1 || b_str != 0) begin
      n_fail++;
      $display("FAIL no_misaligned_span lat=%0d err=%b strobes=%0d exp lat=1 err=1 strobes=0",
               b_lat, b_err, b_str);
    end
    b_req(3'b010, 32'h108, b_lat, b_err, b_str, b_addr);
    n_tests++;
    if (b_lat != 3 || b_err !== 1'b0 || b_str != 1 || b_addr !== 32'h108) begin
      n_fail++;
      $display("FAIL no_misaligned_aligned lat=%0d err=%b strobes=%0d addr=%h exp lat=3 err=0 strobes=1 addr=108",
               b_lat, b_err, b_str, b_addr);
    end
  endtask

  task automatic test_wrap();
    bit got; logic [32:0] act; int lat; exp_t e;
    clear_mon();
    send(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b0, 32'h77881122, 4, 1'b1);
    collect(got, act, lat);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || act !== {e.err, e.rd} || lat != e.lat) begin
      n_fail++;
      $display("FAIL wrap_resp got=%0b rdata=%h lat=%0d exp rdata=%h lat=%0d", got, act[31:0], lat, e.rd, e.lat);
    end
    n_tests++;
    if (re_addr_q.size() != 2 || re_addr_q[0] !== 32'hFFFFFFFC || re_addr_q[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr reads=%0d exp fffffffc then 00000000", re_addr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    // Reset is sampled on the edge that would start the second word of a spanning sw.
    send(1'b1, 3'b010, 32'h111, 32'haabbccdd, 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state rdy=%b we=%b vld=%b exp 1 0 0", req_ready, mem_we, resp_valid);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (we_cnt != 1 || act_q.size() != 0 || mem[32'h110 >> 2] !== 32'hbbccdd00 || mem[32'h114 >> 2] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_effect we=%0d resps=%0d m110=%h m114=%h exp 1 0 bbccdd00 00000000",
               we_cnt, act_q.size(), mem[32'h110 >> 2], mem[32'h114 >> 2]);
    end
  endtask

  task automatic test_back_to_back();
    bit got; logic [32:0] act; int lat; exp_t e; int acc1, acc2;
    send(1'b0, 3'b100, 32'h108, 32'h0, 1'b0, 32'h000000ef, 3, 1'b1);
    acc1 = last_acc;
    send(1'b0, 3'b101, 32'h10E, 32'h0, 1'b0, 32'h0000c001, 3, 1'b1);
    acc2 = last_acc;
    n_tests++;
    if (acc2 - acc1 != 4) begin
      n_fail++;
      $display("FAIL b2b_accept_gap got %0d cycles exp 4", acc2 - acc1);
    end
    for (int i = 0; i < 2; i++) begin
      collect(got, act, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (!got || act !== {e.err, e.rd} || lat != e.lat) begin
        n_fail++;
        $display("FAIL b2b_resp[%0d] got=%0b rdata=%h lat=%0d exp rdata=%h lat=%0d",
                 i, got, act[31:0], lat, e.rd, e.lat);
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (act_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_extra_resp got %0d extra pulses exp 0", act_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h104 >> 2] = 32'hdeadc0de;
    mem[32'h108 >> 2] = 32'hdeadbeef;
    mem[32'h10C >> 2] = 32'hc001c0de;
    mem[1023]         = 32'h11223344;
    mem[0]            = 32'h55667788;
    rst = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0; req_we = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; mem_rd_b = 32'h0;
    clear_mon();
    test_reset();
    test_aligned_loads();
    test_store_byte();
    test_span_load();
    test_span_store();
    test_errors();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
